md_price_level_book: RTL and testbench

//  Parametrised multi-depth MDP3 price-level order book for a single security. Sits after
//  MDP3_Parser and applies each decoded incremental-refresh entry (New/Change/Delete/Clear)
//  to the bid and ask ladders at the entry's price level. Exposes both full ladders as flat

---
 rtl/md_price_level_book_if.sv | 29 ++
 rtl/md_price_level_book.sv | 166 ++++++++++++++++
 tb/tb_md_price_level_book.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_price_level_book_if.sv
// Decoded incremental-refresh entry bus from the MDP3 parser into the price-level book.
// The parser is the master; the book answers with orderbook_ready.
interface md_price_level_book_if #(
    parameter int PRICE_W = 64,
    parameter int QTY_W   = 16,
    parameter int NORD_W  = 8
) ();
    logic               message_ready;
    logic               orderbook_ready;
    logic [31:0]        SECURITY_ID;
    logic [1:0]         ACTION;
    logic [1:0]         ENTRY_TYPE;
    logic [7:0]         PRICE_LEVEL;
    logic [PRICE_W-1:0] PRICE;
    logic [QTY_W-1:0]   QUANTITY;
    logic [NORD_W-1:0]  NUM_ORDERS;

    modport master (
        output message_ready, SECURITY_ID, ACTION, ENTRY_TYPE, PRICE_LEVEL,
               PRICE, QUANTITY, NUM_ORDERS,
        input  orderbook_ready
    );

    modport slave (
        input  message_ready, SECURITY_ID, ACTION, ENTRY_TYPE, PRICE_LEVEL,
               PRICE, QUANTITY, NUM_ORDERS,
        output orderbook_ready
    );
endinterface

// File: rtl/md_price_level_book.sv
// Single-security MDP3 price-level book: two-stage pipeline (register/classify, then apply)
// maintaining bid and ask ladders of DEPTH levels, each level stored as {price,qty,nord}.
module md_price_level_book #(
    parameter logic [31:0] SEC_ID  = 32'd123,
    parameter int          DEPTH   = 10,
    parameter int          PRICE_W = 64,
    parameter int          QTY_W   = 16,
    parameter int          NORD_W  = 8,
    parameter int          CNT_W   = 32
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    md_price_level_book_if.slave                        ent,
    output logic [DEPTH*(PRICE_W+QTY_W+NORD_W)-1:0]     bid_book,
    output logic [DEPTH*(PRICE_W+QTY_W+NORD_W)-1:0]     ask_book,
    output logic                                        book_updated,
    output logic                                        tob_changed,
    output logic                                        reject,
    output logic [CNT_W-1:0]                            msg_count
);
    localparam int ENTRY_W = PRICE_W + QTY_W + NORD_W;

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef enum logic [1:0] {
        ACT_NEW    = 2'd0,
        ACT_CHANGE = 2'd1,
        ACT_DELETE = 2'd2,
        ACT_CLEAR  = 2'd3
    } action_e;

    logic              ready_q, ready_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_matched_q, s1_matched_d;
    logic              s1_bad_q, s1_bad_d;
    action_e           s1_action_q, s1_action_d;
    logic              s1_side_q, s1_side_d;
    logic [7:0]        s1_level_q, s1_level_d;
    entry_t            s1_entry_q, s1_entry_d;

    entry_t            bid_q [DEPTH];
    entry_t            bid_d [DEPTH];
    entry_t            ask_q [DEPTH];
    entry_t            ask_d [DEPTH];
    logic              book_updated_q, book_updated_d;
    logic              tob_changed_q, tob_changed_d;
    logic              reject_q, reject_d;
    logic [CNT_W-1:0]  msg_count_q, msg_count_d;

    entry_t            side_old [DEPTH];
    entry_t            shift_dn [DEPTH];
    entry_t            shift_up [DEPTH];
    entry_t            side_new [DEPTH];
    logic [7:0]        lvl_idx;
    logic              apply;

    // Stage 1: capture and classify the entry offered this cycle.
    always_comb begin
        ready_d      = 1'b1;
        s1_valid_d   = ent.message_ready & ready_q;
        s1_matched_d = (ent.SECURITY_ID == SEC_ID);
        s1_bad_d     = ent.ENTRY_TYPE[1]
                     | ((ent.ACTION != 2'd3)
                        & ((ent.PRICE_LEVEL == 8'd0) | (ent.PRICE_LEVEL > 8'(DEPTH))));
        s1_action_d  = action_e'(ent.ACTION);
        s1_side_d    = ent.ENTRY_TYPE[0];
        s1_level_d   = ent.PRICE_LEVEL;
        s1_entry_d   = {ent.PRICE, ent.QUANTITY, ent.NUM_ORDERS};
    end

    // Stage 2: build the modified ladder for the selected side, then commit it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            side_old[i] = s1_side_q ? ask_q[i] : bid_q[i];
        end
        lvl_idx = s1_level_q - 8'd1;

        shift_dn[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            shift_dn[i] = side_old[i-1];
        end
        shift_up[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_up[i] = side_old[i+1];
        end

        for (int i = 0; i < DEPTH; i++) begin
            side_new[i] = side_old[i];
            case (s1_action_q)
                ACT_NEW: begin
                    if (8'(i) == lvl_idx)     side_new[i] = s1_entry_q;
                    else if (8'(i) > lvl_idx) side_new[i] = shift_dn[i];
                end
                ACT_CHANGE: begin
                    if (8'(i) == lvl_idx)     side_new[i] = s1_entry_q;
                end
                ACT_DELETE: begin
                    if (8'(i) >= lvl_idx)     side_new[i] = shift_up[i];
                end
                default:                      side_new[i] = '0;
            endcase
        end

        apply = s1_valid_q & s1_matched_q & ~s1_bad_q;

        for (int i = 0; i < DEPTH; i++) begin
            bid_d[i] = bid_q[i];
            ask_d[i] = ask_q[i];
            if (apply && !s1_side_q) bid_d[i] = side_new[i];
            if (apply &&  s1_side_q) ask_d[i] = side_new[i];
        end

        book_updated_d = apply;
        tob_changed_d  = apply & (side_new[0] != side_old[0]);
        reject_d       = s1_valid_q & s1_matched_q & s1_bad_q;
        msg_count_d    = msg_count_q + CNT_W'(apply);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q        <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_matched_q   <= 1'b0;
            s1_bad_q       <= 1'b0;
            s1_action_q    <= ACT_NEW;
            s1_side_q      <= 1'b0;
            s1_level_q     <= '0;
            s1_entry_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bid_q[i] <= '0;
                ask_q[i] <= '0;
            end
            book_updated_q <= 1'b0;
            tob_changed_q  <= 1'b0;
            reject_q       <= 1'b0;
            msg_count_q    <= '0;
        end else begin
            ready_q        <= ready_d;
            s1_valid_q     <= s1_valid_d;
            s1_matched_q   <= s1_matched_d;
            s1_bad_q       <= s1_bad_d;
            s1_action_q    <= s1_action_d;
            s1_side_q      <= s1_side_d;
            s1_level_q     <= s1_level_d;
            s1_entry_q     <= s1_entry_d;
            for (int i = 0; i < DEPTH; i++) begin
                bid_q[i] <= bid_d[i];
                ask_q[i] <= ask_d[i];
            end
            book_updated_q <= book_updated_d;
            tob_changed_q  <= tob_changed_d;
            reject_q       <= reject_d;
            msg_count_q    <= msg_count_d;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign bid_book[k*ENTRY_W +: ENTRY_W] = bid_q[k];
        assign ask_book[k*ENTRY_W +: ENTRY_W] = ask_q[k];
    end

    assign ent.orderbook_ready = ready_q;
    assign book_updated        = book_updated_q;
    assign tob_changed         = tob_changed_q;
    assign reject              = reject_q;
    assign msg_count           = msg_count_q;
endmodule

// File: tb/tb_md_price_level_book.sv
// Scoreboard bench for md_price_level_book: a bench-side ladder model queues the expected
// outputs of every driven entry; a monitor pops and compares them when they fall due.
module tb_md_price_level_book;
    localparam int DEPTH = 10;
    localparam int EW    = 88;
    localparam int BW    = DEPTH * EW;

    typedef struct {
        longint           due;
        logic             upd;
        logic             tob;
        logic             rej;
        logic [31:0]      cnt;
        logic [BW-1:0]    bid;
        logic [BW-1:0]    ask;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic [BW-1:0]   bid_book, ask_book;
    logic            book_updated, tob_changed, reject;
    logic [31:0]     msg_count;

    md_price_level_book_if ifc ();

    md_price_level_book dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ent          (ifc),
        .bid_book     (bid_book),
        .ask_book     (ask_book),
        .book_updated (book_updated),
        .tob_changed  (tob_changed),
        .reject       (reject),
        .msg_count    (msg_count)
    );

    int            checks   = 0;
    int            failures = 0;
    longint        cyc      = 0;
    exp_t          sb[$];
    logic [EW-1:0] mbid [DEPTH];
    logic [EW-1:0] mask [DEPTH];
    logic [31:0]   mcount;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] flat_bid();
        logic [BW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*EW +: EW] = mbid[i];
        return f;
    endfunction

    function automatic logic [BW-1:0] flat_ask();
        logic [BW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*EW +: EW] = mask[i];
        return f;
    endfunction

    // Monitor: results for the entry accepted at posedge N appear after posedge N+1.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks += 6;
            if (book_updated !== e.upd) begin
                failures++;
                $display("FAIL sb_book_updated got=%b exp=%b", book_updated, e.upd);
            end
            if (tob_changed !== e.tob) begin
                failures++;
                $display("FAIL sb_tob_changed got=%b exp=%b", tob_changed, e.tob);
            end
            if (reject !== e.rej) begin
                failures++;
                $display("FAIL sb_reject got=%b exp=%b", reject, e.rej);
            end
            if (msg_count !== e.cnt) begin
                failures++;
                $display("FAIL sb_msg_count got=%0d exp=%0d", msg_count, e.cnt);
            end
            if (bid_book !== e.bid) begin
                failures++;
                $display("FAIL sb_bid_book got=%h exp=%h", bid_book, e.bid);
            end
            if (ask_book !== e.ask) begin
                failures++;
                $display("FAIL sb_ask_book got=%h exp=%h", ask_book, e.ask);
            end
        end
    end

    task automatic drive_entry(input logic [31:0] sec, input logic [1:0] act,
                               input logic [1:0] typ, input logic [7:0] lvl,
                               input logic [63:0] p, input logic [15:0] q,
                               input logic [7:0] n, input bit track);
        exp_t          e;
        logic [EW-1:0] s [DEPTH];
        logic [EW-1:0] old0;
        logic          matched, bad;
        int            l;
        @(negedge clk);
        ifc.message_ready = 1'b1;
        ifc.SECURITY_ID   = sec;
        ifc.ACTION        = act;
        ifc.ENTRY_TYPE    = typ;
        ifc.PRICE_LEVEL   = lvl;
        ifc.PRICE         = p;
        ifc.QUANTITY      = q;
        ifc.NUM_ORDERS    = n;
        e.due = cyc + 2;
        e.upd = 1'b0;
        e.tob = 1'b0;
        e.rej = 1'b0;
        matched = (sec == 32'd123);
        bad = (typ > 2'd1) || (act != 2'd3 && (lvl == 8'd0 || lvl > 8'd10));
        if (track && matched && !bad) begin
            for (int i = 0; i < DEPTH; i++) s[i] = (typ == 2'd1) ? mask[i] : mbid[i];
            old0 = s[0];
            l = int'(lvl) - 1;
            case (act)
                2'd0: begin
                    for (int i = DEPTH - 1; i > l; i--) s[i] = s[i-1];
                    s[l] = {p, q, n};
                end
                2'd1: s[l] = {p, q, n};
                2'd2: begin
                    for (int i = l; i < DEPTH - 1; i++) s[i] = s[i+1];
                    s[DEPTH-1] = '0;
                end
                default: for (int i = 0; i < DEPTH; i++) s[i] = '0;
            endcase
            for (int i = 0; i < DEPTH; i++) begin
                if (typ == 2'd1) mask[i] = s[i];
                else             mbid[i] = s[i];
            end
            e.upd = 1'b1;
            e.tob = (s[0] != old0);
            mcount = mcount + 32'd1;
        end
        e.rej = matched && bad;
        e.cnt = mcount;
        e.bid = flat_bid();
        e.ask = flat_ask();
        if (track) sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        ifc.message_ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ifc.message_ready = 1'b0;
        ifc.SECURITY_ID   = '0;
        ifc.ACTION        = '0;
        ifc.ENTRY_TYPE    = '0;
        ifc.PRICE_LEVEL   = '0;
        ifc.PRICE         = '0;
        ifc.QUANTITY      = '0;
        ifc.NUM_ORDERS    = '0;
        mcount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mbid[i] = '0;
            mask[i] = '0;
        end
        repeat (3) @(negedge clk);
        checks += 4;
        if (ifc.orderbook_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", ifc.orderbook_ready);
        end
        if (msg_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", msg_count);
        end
        if (bid_book !== '0 || ask_book !== '0) begin
            failures++;
            $display("FAIL reset_books got=%h/%h exp=0", bid_book[EW-1:0], ask_book[EW-1:0]);
        end
        if ({book_updated, tob_changed, reject} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=000", {book_updated, tob_changed, reject});
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (ifc.orderbook_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_clk got=%b exp=0", ifc.orderbook_ready);
        end
        @(negedge clk);
        checks++;
        if (ifc.orderbook_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_clk got=%b exp=1", ifc.orderbook_ready);
        end
    endtask

    task automatic test_new_bid();
        drive_entry(32'd123, 2'd0, 2'd0, 8'd1, 64'hAE, 16'd9, 8'd1, 1'b1);
        drive_entry(32'd123, 2'd0, 2'd0, 8'd1, 64'h05, 16'd5, 8'd2, 1'b1);
        idle(3);
        checks += 3;
        if (bid_book[0 +: EW] !== {64'h05, 16'd5, 8'd2}) begin
            failures++;
            $display("FAIL new_bid_l1 got=%h exp=%h", bid_book[0 +: EW], {64'h05, 16'd5, 8'd2});
        end
        if (bid_book[EW +: EW] !== {64'hAE, 16'd9, 8'd1}) begin
            failures++;
            $display("FAIL new_bid_l2 got=%h exp=%h", bid_book[EW +: EW], {64'hAE, 16'd9, 8'd1});
        end
        if (msg_count !== 32'd2) begin
            failures++;
            $display("FAIL new_bid_count got=%0d exp=2", msg_count);
        end
    endtask

    task automatic test_fill_asks();
        for (int k = 1; k <= DEPTH; k++)
            drive_entry(32'd123, 2'd0, 2'd1, 8'(k), 64'(32'h100 + k), 16'(k), 8'd1, 1'b1);
        drive_entry(32'd123, 2'd0, 2'd1, 8'd3, 64'h77, 16'd3, 8'd1, 1'b1);
        idle(3);
        checks++;
        if (ask_book[2*EW +: EW] !== {64'h77, 16'd3, 8'd1}) begin
            failures++;
            $display("FAIL ask_insert_l3 got=%h exp=%h", ask_book[2*EW +: EW], {64'h77, 16'd3, 8'd1});
        end
        drive_entry(32'd123, 2'd2, 2'd1, 8'd1, 64'hDEAD, 16'd7, 8'd7, 1'b1);
        drive_entry(32'd123, 2'd2, 2'd1, 8'd10, 64'h0, 16'd0, 8'd0, 1'b1);
        drive_entry(32'd123, 2'd0, 2'd1, 8'd10, 64'h99, 16'd4, 8'd2, 1'b1);
        idle(3);
        checks += 2;
        if (ask_book[EW +: EW] !== {64'h77, 16'd3, 8'd1}) begin
            failures++;
            $display("FAIL ask_delete_shift got=%h exp=%h", ask_book[EW +: EW], {64'h77, 16'd3, 8'd1});
        end
        if (ask_book[9*EW +: EW] !== {64'h99, 16'd4, 8'd2}) begin
            failures++;
            $display("FAIL ask_last_level got=%h exp=%h", ask_book[9*EW +: EW], {64'h99, 16'd4, 8'd2});
        end
    endtask

    task automatic test_change_clear();
        drive_entry(32'd123, 2'd1, 2'd0, 8'd2, 64'hAE, 16'd12, 8'd1, 1'b1);
        idle(3);
        checks++;
        if (bid_book[EW +: EW] !== {64'hAE, 16'd12, 8'd1}) begin
            failures++;
            $display("FAIL change_bid_l2 got=%h exp=%h", bid_book[EW +: EW], {64'hAE, 16'd12, 8'd1});
        end
        drive_entry(32'd123, 2'd3, 2'd0, 8'd0, 64'h0, 16'd0, 8'd0, 1'b1);
        idle(3);
        checks += 2;
        if (bid_book !== '0) begin
            failures++;
            $display("FAIL clear_bid got=%h exp=0", bid_book[EW-1:0]);
        end
        if (ask_book !== flat_ask()) begin
            failures++;
            $display("FAIL clear_ask_untouched got=%h exp=%h", ask_book[EW-1:0], mask[0]);
        end
    endtask

    task automatic test_filter_reject();
        logic [31:0] cnt_before;
        cnt_before = mcount;
        drive_entry(32'd122, 2'd0, 2'd0, 8'd1, 64'h11, 16'd1, 8'd1, 1'b1);
        drive_entry(32'd123, 2'd0, 2'd0, 8'd0, 64'h22, 16'd2, 8'd1, 1'b1);
        drive_entry(32'd123, 2'd1, 2'd1, 8'd11, 64'h33, 16'd3, 8'd1, 1'b1);
        drive_entry(32'd123, 2'd0, 2'd2, 8'd1, 64'h44, 16'd4, 8'd1, 1'b1);
        drive_entry(32'd122, 2'd3, 2'd1, 8'd0, 64'h0, 16'd0, 8'd0, 1'b1);
        idle(3);
        checks++;
        if (msg_count !== cnt_before) begin
            failures++;
            $display("FAIL reject_count_hold got=%0d exp=%0d", msg_count, cnt_before);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 30; k++) begin
            drive_entry(32'd123, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)),
                        8'($urandom_range(1, DEPTH)), {32'h0, $urandom}, 16'($urandom),
                        8'($urandom), 1'b1);
        end
        idle(3);
        checks += 2;
        if (bid_book !== flat_bid()) begin
            failures++;
            $display("FAIL b2b_bid got=%h exp=%h", bid_book, flat_bid());
        end
        if (ask_book !== flat_ask()) begin
            failures++;
            $display("FAIL b2b_ask got=%h exp=%h", ask_book, flat_ask());
        end
    endtask

    task automatic test_reset_mid();
        drive_entry(32'd123, 2'd0, 2'd0, 8'd1, 64'h55, 16'd5, 8'd5, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        checks += 2;
        if (bid_book !== '0 || ask_book !== '0) begin
            failures++;
            $display("FAIL midrst_books got=%h/%h exp=0", bid_book[EW-1:0], ask_book[EW-1:0]);
        end
        if (book_updated !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pulse got=%b exp=0", book_updated);
        end
        mcount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mbid[i] = '0;
            mask[i] = '0;
        end
        @(negedge clk);
        ifc.message_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks += 2;
        if (bid_book !== '0 || msg_count !== 32'd0) begin
            failures++;
            $display("FAIL midrst_after got=%h cnt=%0d exp=0", bid_book[EW-1:0], msg_count);
        end
        if (book_updated !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after_pulse got=%b exp=0", book_updated);
        end
        drive_entry(32'd123, 2'd0, 2'd1, 8'd1, 64'h66, 16'd6, 8'd6, 1'b1);
        idle(3);
    endtask

    initial begin
        int n;
        test_reset();
        test_new_bid();
        test_fill_asks();
        test_change_clear();
        test_filter_reject();
        test_back_to_back();
        test_reset_mid();
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
